// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard unit.
//   ZERO_REG    : architectural register that is hard-wired to zero
//   ld_state_e  : load-stall FSM state encoding
//   slot_match  : per-slot source/destination compare that ignores ZERO_REG
package hazard_pkg;

  localparam int ZERO_REG = 0;

  typedef enum logic {
    IDLE,
    LSTALL
  } ld_state_e;

  // Operands are zero-extended to 32 bits by the caller, so one function
  // serves every REG_W the unit is built with.
  function automatic logic slot_match(input logic        used,
                                      input logic [31:0] src,
                                      input logic [31:0] rd);
    return used && (src == rd) && (rd != 32'(ZERO_REG));
  endfunction

endpackage

// File: rtl/stall_counter.sv
// Parametrised-width down-counter used for the load-stall and mult/div timers.
// Ports:
//   clk      in  rising-edge clock
//   clear    in  synchronous clear (highest priority)
//   load     in  load load_val
//   load_val in  W-bit reload value
//   dec      in  decrement by one, saturating at zero
//   count    out current value
//   zero     out count == 0
module stall_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit for the 5-stage MIPS core. Detects load-use hazards
// (with multi-cycle stalls for slow memory), interlocks dependent instructions
// against an iterative mult/div unit, and flushes on a taken branch, which
// takes priority over any stall.
// Ports:
//   Clock          in  rising-edge clock
//   Reset          in  synchronous, active-high
//   Src_ID         in  packed ID source register numbers, slot i at [i*REG_W +: REG_W]
//   SrcUsed_ID     in  bit i set when slot i is read
//   MulDivUse_ID   in  ID instruction reads HI/LO or starts a mult/div
//   Rd_EX          in  destination register of the EX instruction
//   MemRead_EX     in  EX instruction is a load
//   RegWrite_EX    in  EX instruction writes Rd_EX
//   MulDivStart_EX in  mult/div issues from EX this cycle
//   BranchTaken_EX in  branch/jump in EX resolved taken
//   Stall          out hold PC and IF/ID
//   Bubble_EX      out load a NOP into ID/EX
//   Flush_IFID     out clear IF/ID
//   MulDivBusy     out mult/div unit still computing
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_LAT   = 1,
  parameter int MULDIV_LAT = 32
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [NUM_SRC*REG_W-1:0] Src_ID,
  input  logic [NUM_SRC-1:0]       SrcUsed_ID,
  input  logic                     MulDivUse_ID,
  input  logic [REG_W-1:0]         Rd_EX,
  input  logic                     MemRead_EX,
  input  logic                     RegWrite_EX,
  input  logic                     MulDivStart_EX,
  input  logic                     BranchTaken_EX,
  output logic                     Stall,
  output logic                     Bubble_EX,
  output logic                     Flush_IFID,
  output logic                     MulDivBusy
);

  localparam int LD_W = $clog2(LOAD_LAT + 1);
  localparam int MD_W = $clog2(MULDIV_LAT + 1);

  ld_state_e         state_q, state_d;
  logic              load_match;
  logic              load_stall;
  logic              ld_load, ld_dec, ld_zero;
  logic [LD_W-1:0]   ldcnt;
  logic [MD_W-1:0]   mdcnt;
  logic              md_zero;
  logic              md_stall;

  // NOTE: every variable written in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    load_match = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (slot_match(SrcUsed_ID[i], 32'(Src_ID[i*REG_W +: REG_W]), 32'(Rd_EX))) begin
        load_match = 1'b1;
      end
    end
    load_match = load_match & MemRead_EX & RegWrite_EX;
  end

  // Load-stall FSM. IDLE covers the first stall cycle itself; LSTALL covers
  // the remaining LOAD_LAT-1 cycles counted down by ldcnt.
  always_comb begin
    state_d    = state_q;
    ld_load    = 1'b0;
    ld_dec     = 1'b0;
    load_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_match) begin
          load_stall = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = LSTALL;
            ld_load = 1'b1;
          end
        end
      end
      LSTALL: begin
        load_stall = 1'b1;
        ld_dec     = 1'b1;
        // Leave when this decrement brings the count to zero.
        if (ld_zero || (ldcnt == LD_W'(1))) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // The stalled ID instruction is wrong-path once a branch is taken.
    if (BranchTaken_EX) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  stall_counter #(.W(LD_W)) u_ldcnt (
    .clk      (Clock),
    .clear    (Reset | BranchTaken_EX),
    .load     (ld_load),
    .load_val (LD_W'(LOAD_LAT - 1)),
    .dec      (ld_dec),
    .count    (ldcnt),
    .zero     (ld_zero)
  );

  // The mult/div is older than any branch in EX, so a taken branch leaves
  // this counter running.
  stall_counter #(.W(MD_W)) u_mdcnt (
    .clk      (Clock),
    .clear    (Reset),
    .load     (MulDivStart_EX),
    .load_val (MD_W'(MULDIV_LAT)),
    .dec      (1'b1),
    .count    (mdcnt),
    .zero     (md_zero)
  );

  assign md_stall = ~md_zero & MulDivUse_ID;

  always_comb begin
    Stall      = 1'b1;
    Bubble_EX  = 1'b1;
    Flush_IFID = 1'b1;
    MulDivBusy = 1'b0;
    if (!Reset) begin
      Stall      = (load_stall | md_stall) & ~BranchTaken_EX;
      Bubble_EX  = Stall | BranchTaken_EX;
      Flush_IFID = BranchTaken_EX;
      MulDivBusy = ~md_zero;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit. Three instances cover the default
// parameters (a), LOAD_LAT=3/MULDIV_LAT=4 (b) and NUM_SRC=3/REG_W=6 (c).
module tb_hazard_unit;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Instance a: defaults
  logic [9:0] a_src;  logic [1:0] a_used; logic a_mdu; logic [4:0] a_rd;
  logic a_mr, a_rw, a_mds, a_br;
  logic a_stall, a_bubble, a_flush, a_busy;
  // Instance b: LOAD_LAT=3, MULDIV_LAT=4
  logic [9:0] b_src;  logic [1:0] b_used; logic b_mdu; logic [4:0] b_rd;
  logic b_mr, b_rw, b_mds, b_br;
  logic b_stall, b_bubble, b_flush, b_busy;
  // Instance c: NUM_SRC=3, REG_W=6
  logic [17:0] c_src; logic [2:0] c_used; logic c_mdu; logic [5:0] c_rd;
  logic c_mr, c_rw, c_mds, c_br;
  logic c_stall, c_bubble, c_flush, c_busy;

  hazard_unit dut_a (
    .Clock(Clock), .Reset(Reset), .Src_ID(a_src), .SrcUsed_ID(a_used),
    .MulDivUse_ID(a_mdu), .Rd_EX(a_rd), .MemRead_EX(a_mr), .RegWrite_EX(a_rw),
    .MulDivStart_EX(a_mds), .BranchTaken_EX(a_br), .Stall(a_stall),
    .Bubble_EX(a_bubble), .Flush_IFID(a_flush), .MulDivBusy(a_busy)
  );

  hazard_unit #(.LOAD_LAT(3), .MULDIV_LAT(4)) dut_b (
    .Clock(Clock), .Reset(Reset), .Src_ID(b_src), .SrcUsed_ID(b_used),
    .MulDivUse_ID(b_mdu), .Rd_EX(b_rd), .MemRead_EX(b_mr), .RegWrite_EX(b_rw),
    .MulDivStart_EX(b_mds), .BranchTaken_EX(b_br), .Stall(b_stall),
    .Bubble_EX(b_bubble), .Flush_IFID(b_flush), .MulDivBusy(b_busy)
  );

  hazard_unit #(.REG_W(6), .NUM_SRC(3)) dut_c (
    .Clock(Clock), .Reset(Reset), .Src_ID(c_src), .SrcUsed_ID(c_used),
    .MulDivUse_ID(c_mdu), .Rd_EX(c_rd), .MemRead_EX(c_mr), .RegWrite_EX(c_rw),
    .MulDivStart_EX(c_mds), .BranchTaken_EX(c_br), .Stall(c_stall),
    .Bubble_EX(c_bubble), .Flush_IFID(c_flush), .MulDivBusy(c_busy)
  );

  typedef struct {
    logic [9:0] src;
    logic [1:0] used;
    logic       mdu;
    logic [4:0] rd;
    logic       mr;
    logic       rw;
    logic       br;
    logic       stall;
    logic       bubble;
    logic       flush;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_a(input string n, input logic s, input logic b, input logic f, input logic busy);
    check({n, ".stall"},  32'(a_stall),  32'(s));
    check({n, ".bubble"}, 32'(a_bubble), 32'(b));
    check({n, ".flush"},  32'(a_flush),  32'(f));
    check({n, ".busy"},   32'(a_busy),   32'(busy));
  endtask

  task automatic chk_b(input string n, input logic s, input logic b, input logic f, input logic busy);
    check({n, ".stall"},  32'(b_stall),  32'(s));
    check({n, ".bubble"}, 32'(b_bubble), 32'(b));
    check({n, ".flush"},  32'(b_flush),  32'(f));
    check({n, ".busy"},   32'(b_busy),   32'(busy));
  endtask

  task automatic chk_c(input string n, input logic s, input logic b, input logic f, input logic busy);
    check({n, ".stall"},  32'(c_stall),  32'(s));
    check({n, ".bubble"}, 32'(c_bubble), 32'(b));
    check({n, ".flush"},  32'(c_flush),  32'(f));
    check({n, ".busy"},   32'(c_busy),   32'(busy));
  endtask

  task automatic step;
    @(posedge Clock);
    #1;
  endtask

  task automatic quiet_all;
    a_src = '0; a_used = '0; a_mdu = 0; a_rd = '0; a_mr = 0; a_rw = 0; a_mds = 0; a_br = 0;
    b_src = '0; b_used = '0; b_mdu = 0; b_rd = '0; b_mr = 0; b_rw = 0; b_mds = 0; b_br = 0;
    c_src = '0; c_used = '0; c_mdu = 0; c_rd = '0; c_mr = 0; c_rw = 0; c_mds = 0; c_br = 0;
  endtask

  // Watchdog: the stimulus is fixed-length, this only guards against a hang.
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    //            src              used   mdu rd    mr rw br  stall bub flush
    vecs[0] = '{{5'd7, 5'd5},  2'b11, 0, 5'd5, 1, 1, 0,  1, 1, 0}; // LW $5 / ADD $6,$5,$7
    vecs[1] = '{{5'd7, 5'd5},  2'b10, 0, 5'd5, 1, 1, 0,  0, 0, 0}; // slot 0 not read
    vecs[2] = '{{5'd0, 5'd0},  2'b11, 0, 5'd0, 1, 1, 0,  0, 0, 0}; // $0 never matches
    vecs[3] = '{{5'd7, 5'd5},  2'b11, 0, 5'd5, 0, 1, 0,  0, 0, 0}; // not a load
    vecs[4] = '{{5'd7, 5'd5},  2'b11, 0, 5'd5, 1, 0, 0,  0, 0, 0}; // no write-back
    vecs[5] = '{{5'd5, 5'd9},  2'b10, 0, 5'd5, 1, 1, 0,  1, 1, 0}; // match on slot 1
    vecs[6] = '{{5'd7, 5'd5},  2'b11, 0, 5'd5, 1, 1, 1,  0, 1, 1}; // branch beats stall
    vecs[7] = '{{5'd0, 5'd0},  2'b00, 0, 5'd0, 0, 0, 1,  0, 1, 1}; // branch alone
    vecs[8] = '{{5'd0, 5'd0},  2'b00, 1, 5'd0, 0, 0, 0,  0, 0, 0}; // HI/LO read, unit idle
    vecs[9] = '{{5'd3, 5'd4},  2'b11, 0, 5'd6, 1, 1, 0,  0, 0, 0}; // load, no dependency

    quiet_all();
    Reset = 1'b1;
    #2;
    chk_a("reset_a", 1, 1, 1, 0);
    chk_b("reset_b", 1, 1, 1, 0);
    chk_c("reset_c", 1, 1, 1, 0);
    step();
    step();
    Reset = 1'b0;
    #1;
    chk_a("quiet_a", 0, 0, 0, 0);
    chk_b("quiet_b", 0, 0, 0, 0);

    // Table-driven combinational checks on the default instance.
    for (int i = 0; i < 10; i++) begin
      a_src = vecs[i].src; a_used = vecs[i].used; a_mdu = vecs[i].mdu; a_rd = vecs[i].rd;
      a_mr = vecs[i].mr; a_rw = vecs[i].rw; a_br = vecs[i].br;
      #1;
      chk_a($sformatf("vec%0d", i), vecs[i].stall, vecs[i].bubble, vecs[i].flush, 1'b0);
      step();
    end
    quiet_all();

    // Default LOAD_LAT=1: one stall cycle, then released.
    a_src = {5'd7, 5'd5}; a_used = 2'b11; a_rd = 5'd5; a_mr = 1; a_rw = 1;
    #1;
    chk_a("lu1_c0", 1, 1, 0, 0);
    step();
    a_rd = '0; a_mr = 0; a_rw = 0;
    #1;
    chk_a("lu1_c1", 0, 0, 0, 0);
    quiet_all();
    step();

    // LOAD_LAT=3: load to $8, ID reads $8 only in slot 1.
    b_src = {5'd8, 5'd3}; b_used = 2'b10; b_rd = 5'd8; b_mr = 1; b_rw = 1;
    #1;
    chk_b("lu3_c0", 1, 1, 0, 0);
    step();
    b_rd = '0; b_mr = 0; b_rw = 0;
    #1;
    chk_b("lu3_c1", 1, 1, 0, 0);
    step();
    chk_b("lu3_c2", 1, 1, 0, 0);
    step();
    chk_b("lu3_c3", 0, 0, 0, 0);

    // Repeat with Rd_EX=0 (slot 1 also $0), then with SrcUsed_ID=0.
    b_src = {5'd0, 5'd3}; b_used = 2'b10; b_rd = 5'd0; b_mr = 1; b_rw = 1;
    #1;
    chk_b("lu3_r0_c0", 0, 0, 0, 0);
    step();
    b_mr = 0; b_rw = 0;
    #1;
    chk_b("lu3_r0_c1", 0, 0, 0, 0);
    b_src = {5'd8, 5'd3}; b_used = 2'b00; b_rd = 5'd8; b_mr = 1; b_rw = 1;
    #1;
    chk_b("lu3_unused_c0", 0, 0, 0, 0);
    step();
    b_mr = 0; b_rw = 0;
    #1;
    chk_b("lu3_unused_c1", 0, 0, 0, 0);
    quiet_all();
    step();

    // MULDIV_LAT=4: start pulse, then MFLO in ID.
    b_mds = 1;
    #1;
    chk_b("md_start", 0, 0, 0, 0);
    step();
    b_mds = 0; b_mdu = 1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk_b($sformatf("md_busy%0d", k), 1, 1, 0, 1);
      step();
    end
    chk_b("md_release", 0, 0, 0, 0);
    quiet_all();
    step();

    // Branch taken in the 2nd cycle of a LOAD_LAT=3 stall.
    b_src = {5'd8, 5'd3}; b_used = 2'b10; b_rd = 5'd8; b_mr = 1; b_rw = 1;
    #1;
    chk_b("lbr_c0", 1, 1, 0, 0);
    step();
    b_rd = '0; b_mr = 0; b_rw = 0; b_br = 1;
    #1;
    chk_b("lbr_c1", 0, 1, 1, 0);
    step();
    b_br = 0;
    #1;
    chk_b("lbr_c2", 0, 0, 0, 0);
    step();
    chk_b("lbr_c3", 0, 0, 0, 0);
    quiet_all();
    step();

    // Reset during a mult/div busy period.
    b_mds = 1;
    step();
    b_mds = 0; b_mdu = 1;
    #1;
    chk_b("rst_md_busy", 1, 1, 0, 1);
    Reset = 1'b1;
    #1;
    chk_b("rst_md_in", 1, 1, 1, 0);
    step();
    Reset = 1'b0;
    quiet_all();
    #1;
    chk_b("rst_md_after", 0, 0, 0, 0);
    b_mdu = 1;
    #1;
    chk_b("rst_md_nobusy", 0, 0, 0, 0);
    quiet_all();
    step();

    // NUM_SRC=3, REG_W=6: match on slot 2 with Rd_EX=33.
    c_src = {6'd33, 6'd1, 6'd2}; c_used = 3'b100; c_rd = 6'd33; c_mr = 1; c_rw = 1;
    #1;
    chk_c("w6_c0", 1, 1, 0, 0);
    step();
    c_rd = '0; c_mr = 0; c_rw = 0;
    #1;
    chk_c("w6_c1", 0, 0, 0, 0);
    c_used = 3'b011; c_rd = 6'd33; c_mr = 1; c_rw = 1;
    #1;
    chk_c("w6_slot2_unused", 0, 0, 0, 0);
    quiet_all();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Parametrised pipeline hazard unit for the 5-stage MIPS core, replacing the single-cycle load-use detector. It sits beside the ID stage and drives the PC/IF-ID write enables, ID/EX bubble insertion and IF/ID flush. It adds four behaviours:
- a configurable source-operand count that ignores register 0;
- multi-cycle load-use stalls for slow memory;
- interlocks for an iterative multiply/divide unit;
- branch-taken flush that takes priority over stalls.

## Interface
Parameters:
- REG_W, 5, register-address width
- NUM_SRC, 2, source operands checked per ID instruction
- LOAD_LAT, 1, load-use stall cycles (≥1)
- MULDIV_LAT, 32, multiply/divide busy cycles (≥1)

Ports:
- Clock  in  1  single clock, rising edge
- Reset  in  1  synchronous, active-high
- Src_ID  in  NUM_SRC*REG_W  packed ID source register numbers; slot i at [i*REG_W +: REG_W]
- SrcUsed_ID  in  NUM_SRC  bit i set when slot i is actually read
- MulDivUse_ID  in  1  ID instruction reads HI/LO or starts a mult/div
- Rd_EX  in  REG_W  destination register of the EX instruction
- MemRead_EX  in  1  EX instruction is a load
- RegWrite_EX  in  1  EX instruction writes Rd_EX
- MulDivStart_EX  in  1  mult/div issues from EX this cycle
- BranchTaken_EX  in  1  branch/jump in EX resolved taken
- Stall  out  1  hold PC and IF/ID
- Bubble_EX  out  1  load a NOP into ID/EX
- Flush_IFID  out  1  clear IF/ID
- MulDivBusy  out  1  mult/div unit still computing

## Operation
- **Load match (LM):** MemRead_EX & RegWrite_EX & Rd_EX≠0 & some i with SrcUsed_ID[i] & Src_ID slot i == Rd_EX. Register 0 never matches.
- **Load-stall FSM, states IDLE and LSTALL.**
  - IDLE: on LM with LOAD_LAT>1, go to LSTALL and set ldcnt = LOAD_LAT-1.
  - LSTALL: decrement ldcnt; when it reaches 0, return to IDLE.
  - Load stall is active in IDLE on LM, and in every LSTALL cycle.
- **Multiply/divide counter (mdcnt):**
  - MulDivStart_EX loads mdcnt = MULDIV_LAT.
  - Otherwise mdcnt decrements while nonzero.
  - MulDivBusy = (mdcnt≠0).
  - Mult/div stall = MulDivBusy & MulDivUse_ID.
  - A new MulDivStart_EX while busy reloads the counter; the interlock upstream normally prevents this.
- **Outputs when not in Reset:**
  - Stall = (load stall | mult/div stall) & ~BranchTaken_EX.
  - Bubble_EX = Stall | BranchTaken_EX.
  - Flush_IFID = BranchTaken_EX.
- **Branch priority:** BranchTaken_EX forces the FSM to IDLE and clears ldcnt on the next edge, because the stalled ID instruction is wrong-path. mdcnt is unaffected, since the mult/div is older than the branch.
- **MulDivStart_EX with BranchTaken_EX in the same cycle:** both take effect.
- **Reset:** outputs are Stall=1, Bubble_EX=1, Flush_IFID=1, MulDivBusy=0. On the reset edge: FSM→IDLE, ldcnt=0, mdcnt=0.

## Timing
- Outputs are combinational from inputs and current state, valid in the same cycle; no added latency.
- State and counters update on the rising edge of Clock only.
- Load-use with LOAD_LAT=N: Stall is high for exactly N consecutive cycles, starting in the cycle LM is first seen.
- Mult/div: started at edge t, MulDivBusy is high for cycles t+1 … t+MULDIV_LAT. A dependent ID instruction stalls through the last busy cycle and proceeds in the first cycle with mdcnt=0.
- Reset asserted mid-stall: outputs take reset values immediately. On deassertion the unit starts in IDLE with no pending stall.
- Counter widths are $clog2(LOAD_LAT+1) and $clog2(MULDIV_LAT+1). Decrements saturate at 0; no wrap-around.

## Structure
- Package `hazard_pkg` holds:
  - ZERO_REG (0)
  - the FSM state encoding {IDLE, LSTALL}
  - a function for the per-slot source match
- Sub-module `stall_counter` holds the parametrised-width down-counter (load, decrement, saturate at 0, synchronous clear, zero flag). It is instantiated twice, for ldcnt and mdcnt.

## Test plan
- Default parameters, LW $5 in EX, ADD $6,$5,$7 in ID (slot 0=5, used) → Stall=1 and Bubble_EX=1 for exactly 1 cycle, then 0.
- LOAD_LAT=3, load to $8, ID reads $8 only in slot 1 → Stall high 3 cycles. Repeating with Rd_EX=0 or SrcUsed_ID=0 → no stall.
- MULDIV_LAT=4, MulDivStart_EX pulse, then MFLO in ID → MulDivBusy high 4 cycles, Stall high for those 4 cycles, released on the 5th.
- LOAD_LAT=3 stall in progress (2nd cycle), BranchTaken_EX=1 → that cycle Stall=0, Flush_IFID=1, Bubble_EX=1. Next cycle FSM is IDLE, with no residual stall.
- Reset asserted during a mult/div busy period → Stall=1, Flush_IFID=1, Bubble_EX=1, MulDivBusy=0. After deassertion with quiet inputs, all outputs are 0.
- NUM_SRC=3, REG_W=6, match on slot 2 with Rd_EX=33 → Stall=1 for one cycle.
